data_mem_master: RTL and testbench
==================================

# data_mem_master

Initiator-side controller for the S-Machine data memory: the block that drives the memory's read_write/addr/data_in lines and consumes its synchronous data_out. It accepts single-word stores and single- or multi-word (burst) loads from the CPU datapath over a valid/ready request channel and returns load data on a response channel. It sits between the execute stage and the data memory.

## Interface
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, data word width
- LEN_W, 4, burst length field width; burst = req_len+1 words (1..16)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  start address
- req_wdata  in  DATA_W  store data (ignored for loads)
- req_len  in  LEN_W  load burst length minus one (ignored for stores)
- rsp_valid  out  1  one load word on rsp_data this cycle
- rsp_data  out  DATA_W  load data
- rsp_last  out  1  final word of the burst (qualified by rsp_valid)
- wr_done  out  1  one-cycle pulse: store committed
- busy  out  1  state != IDLE
- mem_read_write  out  1  to memory: 0 = read, 1 = write
- mem_addr  out  ADDR_W  to memory address
- mem_data_in  out  DATA_W  to memory write data
- mem_data_out  in  DATA_W  from memory, registered read data

## Operation
- States: IDLE, WRITE, READ.
- IDLE: req_ready=1, mem_read_write=0. Accept on req_valid && req_ready (rising edge).
  - req_write=1 -> latch addr/wdata, go WRITE.
  - req_write=0 -> latch addr, remaining = req_len, go READ.
- WRITE (exactly one cycle): mem_read_write=1, mem_addr=latched addr, mem_data_in=latched data; memory commits at the closing edge; -> IDLE; wr_done asserted the following cycle.
- READ: each cycle presents mem_addr = current address, mem_read_write=0; address increments by 1 modulo 2^ADDR_W (0xFF -> 0x00 wrap, no error); remaining decrements; after presenting the address with remaining==0 -> IDLE.
- Response: rsp_valid is a registered copy of "address presented last cycle"; rsp_data = mem_data_out directly (memory output already registered); rsp_last registered alongside for the final address. No backpressure on responses: consumer must take each word when rsp_valid=1.
- req_ready=0 in WRITE and READ; requests offered then are not accepted and must be held by the requester.
- mem_read_write is 1 only in WRITE; never 1 in IDLE/READ/reset.
- mem_addr holds last driven value in IDLE; mem_data_in holds last store data.
- Reset (any time, including mid-burst): state IDLE, counters 0, all outputs 0 (req_ready=1 after reset deasserts); pending burst words are dropped, no further rsp_valid. Memory contents unaffected.

## Timing
- Request accepted at edge E0.
- Store: mem_read_write=1 in cycle 1, commit at E1, wr_done=1 in cycle 2, req_ready=1 in cycle 2. Store-to-store throughput: one per 2 cycles.
- Load of L=req_len+1 words: addresses A..A+L-1 in cycles 1..L; word k (k=0..L-1) on rsp_data with rsp_valid=1 in cycle k+2; rsp_last=1 in cycle L+1 only. req_ready=1 from cycle L+1.
- A request accepted in cycle L+1 (same cycle as the last response) is legal; its first memory cycle is L+2, with no gap or overlap on mem_* lines.
- Store immediately after a load to the same address: load data returned is the pre-store value.
- Load accepted immediately after wr_done-cycle store: returns the newly written value.

## Test plan
- Reset: assert reset mid-cycle with req_valid=1 -> all outputs 0 asynchronously; after release req_ready=1, mem_read_write=0, busy=0.
- Store 0xBEEF to 0x20 then load len=0 from 0x20 -> mem_read_write=1 for exactly one cycle, wr_done pulse 2 cycles after accept; load returns rsp_data=0xBEEF with rsp_valid=rsp_last=1 two cycles after its accept.
- Preload 0x10..0x13 with 0x1111,0x2222,0x3333,0x4444; load addr 0x10 len=3 -> four consecutive rsp_valid cycles in that order, rsp_last only on 0x4444, req_ready low for 4 cycles.
- Wrap: preload 0xFE,0xFF,0x00 with 0xA0,0xA1,0xA2; load 0xFE len=2 -> mem_addr sequence FE,FF,00; responses 0xA0,0xA1,0xA2.
- Busy/back-to-back: hold req_valid with a store during a len=3 burst -> not accepted until the rsp_last cycle; store's write cycle follows immediately; no request lost or duplicated.
- Reset mid-burst: load len=15, assert reset after 5 responses -> rsp_valid drops immediately, no further responses; next load after release starts fresh and returns correct data.

Source files
------------

// File: rtl/data_mem_master.sv
// Initiator-side controller for the S-Machine data memory: single-word stores and
// single/burst loads from the execute stage, load data returned on a response channel.
module data_mem_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_last_o,
    output logic              wr_done_o,
    output logic              busy_o,
    output logic              mem_read_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_in_o,
    input  logic [DATA_W-1:0] mem_data_out_i
);

    // state    | meaning
    // IDLE     | ready for a request, memory idle in read mode
    // WRITE    | one-cycle store, memory commits at the closing edge
    // READ     | one address per cycle until the remaining count reaches zero
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LEN_W-1:0]    remain_q, remain_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_last_q, rsp_last_d;
    logic                wr_done_q, wr_done_d;
    logic                accept;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            remain_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remain_q    <= remain_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign req_ready_o = (state_q == ST_IDLE) && !reset_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        remain_d    = remain_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        wr_done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = req_addr_i;
                    if (req_write_i) begin
                        wdata_d = req_wdata_i;
                        state_d = ST_WRITE;
                    end else begin
                        remain_d = req_len_i;
                        state_d  = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                wr_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_READ: begin
                rsp_valid_d = 1'b1;
                // The final address is not advanced so mem_addr holds the last driven value.
                if (remain_q == '0) begin
                    rsp_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_read_write_o = (state_q == ST_WRITE);
    assign mem_addr_o       = addr_q;
    assign mem_data_in_o    = wdata_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign wr_done_o        = wr_done_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_last_o       = rsp_last_q;
    // Memory output is already registered; masked so the bus reads 0 between words.
    assign rsp_data_o       = rsp_valid_q ? mem_data_out_i : '0;

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master: synchronous memory model, shadow-array reference,
// directed scenarios followed by randomized store/load traffic.
module tb_data_mem_master;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [7:0]  req_addr_i;
    logic [15:0] req_wdata_i;
    logic [3:0]  req_len_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    logic        rsp_last_o;
    logic        wr_done_o;
    logic        busy_o;
    logic        mem_read_write_o;
    logic [7:0]  mem_addr_o;
    logic [15:0] mem_data_in_o;
    logic [15:0] mem_data_out_i;

    data_mem_master dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_len_i(req_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .wr_done_o(wr_done_o), .busy_o(busy_o),
        .mem_read_write_o(mem_read_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_in_o(mem_data_in_o), .mem_data_out_i(mem_data_out_i)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        mem_init;
    int          n_checks = 0;
    int          n_err = 0;
    int          n_stores = 0;
    int          n_wr_cycles = 0;

    function automatic logic [15:0] init_val(int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Synchronous memory: registered read, write commits at the edge.
    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_read_write_o) mem[mem_addr_o] <= mem_data_in_o;
            mem_data_out_i <= mem[mem_addr_o];
        end
    end

    always @(posedge clk_i) begin
        if (!reset_i && mem_read_write_o) n_wr_cycles <= n_wr_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d);
        chk("st_ready_pre", req_ready_o, 1);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = a; req_wdata_i = d;
        req_len_i = 4'($urandom_range(0, 15));
        tick();
        req_valid_i = 1'b0;
        chk("st_rw_c1", mem_read_write_o, 1);
        chk("st_addr_c1", mem_addr_o, a);
        chk("st_din_c1", mem_data_in_o, d);
        chk("st_ready_c1", req_ready_o, 0);
        chk("st_busy_c1", busy_o, 1);
        chk("st_wrdone_c1", wr_done_o, 0);
        tick();
        chk("st_rw_c2", mem_read_write_o, 0);
        chk("st_wrdone_c2", wr_done_o, 1);
        chk("st_ready_c2", req_ready_o, 1);
        chk("st_busy_c2", busy_o, 0);
        chk("st_addr_hold", mem_addr_o, a);
        chk("st_din_hold", mem_data_in_o, d);
        ref_mem[a] = d;
        n_stores++;
    endtask

    // Load of len+1 words; optionally holds a store request during the burst,
    // or asserts reset mid-cycle in cycle abort_c.
    task automatic do_load(input logic [7:0] a, input int len, input bit hold_st,
                           input logic [7:0] sa, input logic [15:0] sd, input int abort_c);
        int L = len + 1;
        chk("ld_ready_pre", req_ready_o, 1);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = a; req_len_i = 4'(len);
        req_wdata_i = 16'($urandom);
        tick();
        req_valid_i = 1'b0;
        if (hold_st) begin
            req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = sa; req_wdata_i = sd;
        end
        for (int c = 1; c <= L + 1; c++) begin
            chk("ld_rw", mem_read_write_o, 0);
            chk("ld_wrdone", wr_done_o, 0);
            if (c <= L) begin
                chk("ld_addr", mem_addr_o, 8'(a + c - 1));
                chk("ld_ready_busy", req_ready_o, 0);
                chk("ld_busy", busy_o, 1);
            end else begin
                chk("ld_ready_end", req_ready_o, 1);
                chk("ld_busy_end", busy_o, 0);
            end
            if (c >= 2) begin
                chk("ld_rvalid", rsp_valid_o, 1);
                chk("ld_rdata", rsp_data_o, ref_mem[8'(a + c - 2)]);
                chk("ld_rlast", rsp_last_o, (c == L + 1));
            end else begin
                chk("ld_rvalid_c1", rsp_valid_o, 0);
            end
            if (abort_c != 0 && c == abort_c) begin
                #3 reset_i = 1'b1;
                #1;
                chk("abort_rvalid", rsp_valid_o, 0);
                chk("abort_rlast", rsp_last_o, 0);
                chk("abort_busy", busy_o, 0);
                chk("abort_rw", mem_read_write_o, 0);
                return;
            end
            if (c <= L) tick();
        end
        if (hold_st) begin
            tick();
            req_valid_i = 1'b0;
            chk("b2b_rw", mem_read_write_o, 1);
            chk("b2b_addr", mem_addr_o, sa);
            chk("b2b_din", mem_data_in_o, sd);
            chk("b2b_rvalid", rsp_valid_o, 0);
            tick();
            chk("b2b_wrdone", wr_done_o, 1);
            chk("b2b_rw_c2", mem_read_write_o, 0);
            ref_mem[sa] = sd;
            n_stores++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; mem_init = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'h33;
        req_wdata_i = 16'h7777; req_len_i = 4'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (2) tick();
        mem_init = 1'b0;
        chk("rst_ready", req_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rw", mem_read_write_o, 0);
        chk("rst_rvalid", rsp_valid_o, 0);
        chk("rst_wrdone", wr_done_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        req_valid_i = 1'b0;
        reset_i = 1'b0;
        #1;
        chk("rel_ready", req_ready_o, 1);
        chk("rel_busy", busy_o, 0);

        // Reset mid-cycle during a store, with a request still offered.
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'h55; req_wdata_i = 16'h1234;
        tick();
        chk("rs_rw_before", mem_read_write_o, 1);
        #3 reset_i = 1'b1;
        #1;
        chk("rs_ready", req_ready_o, 0);
        chk("rs_rw", mem_read_write_o, 0);
        chk("rs_busy", busy_o, 0);
        chk("rs_wrdone", wr_done_o, 0);
        chk("rs_addr", mem_addr_o, 0);
        chk("rs_din", mem_data_in_o, 0);
        chk("rs_rvalid", rsp_valid_o, 0);
        chk("rs_rdata", rsp_data_o, 0);
        tick();
        req_valid_i = 1'b0;
        reset_i = 1'b0;
        #1;
        chk("rs_rel_ready", req_ready_o, 1);
        chk("rs_rel_rw", mem_read_write_o, 0);
        chk("rs_rel_busy", busy_o, 0);
        do_load(8'h55, 0, 0, 0, 0, 0);

        do_store(8'h20, 16'hBEEF);
        do_load(8'h20, 0, 0, 0, 0, 0);

        do_store(8'h10, 16'h1111);
        do_store(8'h11, 16'h2222);
        do_store(8'h12, 16'h3333);
        do_store(8'h13, 16'h4444);
        do_load(8'h10, 3, 0, 0, 0, 0);

        do_store(8'hFE, 16'h00A0);
        do_store(8'hFF, 16'h00A1);
        do_store(8'h00, 16'h00A2);
        do_load(8'hFE, 2, 0, 0, 0, 0);

        // Store held during a burst, targeting a word of that burst.
        do_load(8'h10, 3, 1, 8'h12, 16'hC0DE, 0);
        do_load(8'h12, 0, 0, 0, 0, 0);

        // Reset after five responses of a 16-word burst.
        do_load(8'h40, 15, 0, 0, 0, 6);
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_abort_rvalid", rsp_valid_o, 0);
            chk("post_abort_ready", req_ready_o, 1);
            tick();
        end
        do_load(8'h40, 7, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: do_store(a, 16'($urandom));
                1: do_load(a, int'($urandom_range(0, 15)), 0, 0, 0, 0);
                2: begin
                    do_load(a, int'($urandom_range(0, 3)), 0, 0, 0, 0);
                    do_store(a, 16'($urandom));
                    do_load(a, 0, 0, 0, 0, 0);
                end
                default: do_load(a, int'($urandom_range(0, 15)), 1,
                                 8'($urandom), 16'($urandom), 0);
            endcase
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        chk("store_count", n_wr_cycles, n_stores);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
